// File: rtl/risc16_pkg.sv
// Shared constants for the RISC16 core and its program loader.
package risc16_pkg;

  localparam int MEM_DEPTH = 256;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic TGT_INSTR = 1'b0;
  localparam logic TGT_DATA  = 1'b1;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_TGT  = 4'd1;
  localparam state_t ST_ADDR = 4'd2;
  localparam state_t ST_CNT  = 4'd3;
  localparam state_t ST_HI   = 4'd4;
  localparam state_t ST_LO   = 4'd5;
  localparam state_t ST_WR   = 4'd6;
  localparam state_t ST_CHK  = 4'd7;
  localparam state_t ST_ERR  = 4'd8;

endpackage

// File: rtl/risc16_word_asm.sv
// Pairs payload bytes into big-endian 16-bit words and keeps a running XOR
// over every payload byte.
module risc16_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        accept,
  input  logic        clear,
  output logic [15:0] word,
  output logic        word_valid,
  output logic [7:0]  checksum
);

  logic       phase;
  logic [7:0] hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      hi         <= 8'd0;
      word       <= 16'd0;
      word_valid <= 1'b0;
      checksum   <= 8'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        phase    <= 1'b0;
        checksum <= 8'd0;
      end else if (accept) begin
        checksum <= checksum ^ data_in;
        if (!phase) begin
          hi    <= data_in;
          phase <= 1'b1;
        end else begin
          word       <= {hi, data_in};
          word_valid <= 1'b1;
          phase      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/risc16_prog_loader.sv
// Byte-stream frame loader: writes words into instruction/data memory and
// holds the core stalled until a checksum-verified run frame arrives.
//   IDLE wait for SYNC | TGT/ADDR/CNT header | HI/LO payload | WR write strobe
//   CHK verify XOR     | ERR bad frame or timeout, wait for SYNC
module risc16_prog_loader
  import risc16_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state;
  logic              run_flag;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remain;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [7:0]        checksum;
  logic              xfer;
  logic              asm_accept;
  logic              asm_clear;
  logic              tmo_active;
  logic              tmo_hit;

  assign xfer       = rx_valid && rx_ready;
  assign asm_accept = xfer && (state == ST_HI || state == ST_LO);
  assign asm_clear  = xfer && (state == ST_CNT);
  assign tmo_active = (state == ST_TGT) || (state == ST_ADDR) || (state == ST_CNT) ||
                      (state == ST_HI)  || (state == ST_LO)   || (state == ST_CHK);
  assign tmo_hit    = tmo_active && !xfer && (tmo_cnt == TMO_LAST);

  // The address register advances at the end of WR, so it is the write address.
  assign wr_addr = addr;

  risc16_word_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (rx_data),
    .accept     (asm_accept),
    .clear      (asm_clear),
    .word       (wr_data),
    .word_valid (wr_en),
    .checksum   (checksum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rx_ready <= 1'b1;
      wr_sel   <= TGT_INSTR;
      run_flag <= 1'b0;
      addr     <= '0;
      remain   <= '0;
      tmo_cnt  <= '0;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_ready <= !(state == ST_LO && xfer);

      if (xfer || !tmo_active) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + TMO_W'(1);

      case (state)
        ST_IDLE: begin
          if (xfer && rx_data == SYNC_BYTE) begin
            cpu_run <= 1'b0;
            state   <= ST_TGT;
          end
        end
        ST_TGT: begin
          if (xfer) begin
            wr_sel   <= rx_data[0];
            run_flag <= rx_data[7];
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (xfer) begin
            addr  <= ADDR_W'(rx_data);
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (xfer) begin
            remain <= (rx_data == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(rx_data);
            state  <= ST_HI;
          end
        end
        ST_HI: if (xfer) state <= ST_LO;
        ST_LO: if (xfer) state <= ST_WR;
        ST_WR: begin
          addr   <= addr + ADDR_W'(1);
          remain <= remain - CNT_W'(1);
          state  <= (remain == CNT_W'(1)) ? ST_CHK : ST_HI;
        end
        ST_CHK: begin
          if (xfer) begin
            if (rx_data == checksum) begin
              done  <= 1'b1;
              state <= ST_IDLE;
              if (run_flag) cpu_run <= 1'b1;
            end else begin
              err   <= 1'b1;
              state <= ST_ERR;
            end
          end
        end
        ST_ERR: begin
          if (xfer && rx_data == SYNC_BYTE) begin
            err   <= 1'b0;
            state <= ST_TGT;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (tmo_hit) begin
        err   <= 1'b1;
        state <= ST_ERR;
      end
    end
  end

endmodule
